// File: rtl/mul_batch.sv
// Weight-times-activation batch multiplier sharing one multiplier across duplicate lanes.
// Define MUL_BATCH_SIGNED_EN for two's-complement lane values and weight (default: unsigned).
module mul_batch #(
   parameter int DATA_WIDTH             = 8,
   parameter int GROUP_SIZE             = 4,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int REP_INFO               = GROUP_SIZE*GROUP_SIZE
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    configure,
   input  logic [LOG_MAX_ITERS-1:0]                num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0]       num_reads_per_iter,
   input  logic [GROUP_SIZE*DATA_WIDTH+REP_INFO-1:0] act_data_in,
   input  logic                                    act_valid_in,
   output logic                                    act_avail_out,
   input  logic [DATA_WIDTH-1:0]                   weight_data_in,
   input  logic                                    weight_valid_in,
   output logic                                    weight_avail_out,
   output logic [GROUP_SIZE*2*DATA_WIDTH-1:0]      data_out,
   output logic                                    valid_out,
   input  logic                                    avail_in
);

   localparam int PW    = 2*DATA_WIDTH;
   localparam int SEL_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT_W = 3'd1;
   localparam logic [2:0] S_WAIT_A = 3'd2;
   localparam logic [2:0] S_COMP   = 3'd3;
   localparam logic [2:0] S_OUT    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]                        state_reg;
   logic [LOG_MAX_ITERS-1:0]          iters_reg;
   logic [LOG_MAX_ITERS-1:0]          iter_cnt_reg;
   logic [LOG_MAX_READS_PER_ITER-1:0] reads_reg;
   logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt_reg;
   logic [DATA_WIDTH-1:0]             weight_reg;
   logic [GROUP_SIZE*DATA_WIDTH-1:0]  lanes_reg;
   logic [REP_INFO-1:0]               rep_reg;
   logic [GROUP_SIZE-1:0]             done_reg;
   logic [GROUP_SIZE*PW-1:0]          prod_reg;

   logic [DATA_WIDTH-1:0]             lane_val [GROUP_SIZE];
   logic [GROUP_SIZE-1:0]             rep_row  [GROUP_SIZE];
   logic [GROUP_SIZE-1:0]             row_nz;
   logic [GROUP_SIZE-1:0]             pending;
   logic [GROUP_SIZE-1:0]             sel_onehot;
   logic [SEL_W-1:0]                  sel;
   logic [GROUP_SIZE-1:0]             sel_row;
   logic                              last_row;
   logic [DATA_WIDTH-1:0]             operand;
   logic [PW-1:0]                     operand_ext;
   logic [PW-1:0]                     weight_ext;
   logic [PW-1:0]                     product;
   logic [LOG_MAX_READS_PER_ITER-1:0] reads_eff;
   logic [LOG_MAX_READS_PER_ITER-1:0] reads_last;
   logic [LOG_MAX_ITERS-1:0]          iters_last;

   genvar gi;
   generate
      for (gi = 0; gi < GROUP_SIZE; gi++) begin : g_lane
         assign lane_val[gi] = lanes_reg[gi*DATA_WIDTH +: DATA_WIDTH];
         assign rep_row[gi]  = rep_reg[gi*GROUP_SIZE +: GROUP_SIZE];
         assign row_nz[gi]   = |rep_row[gi];
      end
   endgenerate

   assign pending    = row_nz & ~done_reg;
   assign sel_onehot = pending & (~pending + GROUP_SIZE'(1));
   assign last_row   = ((pending & ~sel_onehot) == '0);

   always_comb begin
      sel = '0;
      for (int r = GROUP_SIZE-1; r >= 0; r--) begin
         if (pending[r]) sel = SEL_W'(r);
      end
   end

   assign sel_row = rep_row[sel];
   assign operand = lane_val[sel];

   // Operands are extended to the full product width so the low PW bits are exact.
`ifdef MUL_BATCH_SIGNED_EN
   assign operand_ext = {{DATA_WIDTH{operand[DATA_WIDTH-1]}}, operand};
   assign weight_ext  = {{DATA_WIDTH{weight_reg[DATA_WIDTH-1]}}, weight_reg};
`else
   assign operand_ext = {{DATA_WIDTH{1'b0}}, operand};
   assign weight_ext  = {{DATA_WIDTH{1'b0}}, weight_reg};
`endif
   assign product = operand_ext * weight_ext;

   assign reads_eff  = (reads_reg == '0) ? LOG_MAX_READS_PER_ITER'(1) : reads_reg;
   assign reads_last = reads_eff - LOG_MAX_READS_PER_ITER'(1);
   assign iters_last = iters_reg - LOG_MAX_ITERS'(1);

   assign act_avail_out    = (state_reg == S_WAIT_A);
   assign weight_avail_out = (state_reg == S_WAIT_W);
   assign valid_out        = (state_reg == S_OUT);
   assign data_out         = prod_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         iters_reg    <= '0;
         iter_cnt_reg <= '0;
         reads_reg    <= '0;
         read_cnt_reg <= '0;
         weight_reg   <= '0;
         lanes_reg    <= '0;
         rep_reg      <= '0;
         done_reg     <= '0;
         prod_reg     <= '0;
      end else if (configure) begin
         iters_reg    <= num_iters;
         reads_reg    <= num_reads_per_iter;
         iter_cnt_reg <= '0;
         read_cnt_reg <= '0;
         rep_reg      <= '0;
         done_reg     <= '0;
         state_reg    <= (num_iters == '0) ? S_DONE : S_WAIT_W;
      end else begin
         case (state_reg)
            S_WAIT_W: begin
               if (weight_valid_in) begin
                  weight_reg <= weight_data_in;
                  state_reg  <= S_WAIT_A;
               end
            end
            S_WAIT_A: begin
               if (act_valid_in) begin
                  lanes_reg <= act_data_in[GROUP_SIZE*DATA_WIDTH-1:0];
                  rep_reg   <= act_data_in[GROUP_SIZE*DATA_WIDTH +: REP_INFO];
                  done_reg  <= '0;
                  prod_reg  <= '0;
                  state_reg <= S_COMP;
               end
            end
            S_COMP: begin
               // Rows go in ascending order, so the highest referencing row lands last.
               if (pending != '0) begin
                  done_reg <= done_reg | sel_onehot;
                  for (int c = 0; c < GROUP_SIZE; c++) begin
                     if (sel_row[c]) prod_reg[c*PW +: PW] <= product;
                  end
               end
               if (last_row) state_reg <= S_OUT;
            end
            S_OUT: begin
               if (avail_in) begin
                  if (read_cnt_reg == reads_last) begin
                     read_cnt_reg <= '0;
                     iter_cnt_reg <= iter_cnt_reg + LOG_MAX_ITERS'(1);
                     state_reg    <= (iter_cnt_reg == iters_last) ? S_DONE : S_WAIT_W;
                  end else begin
                     read_cnt_reg <= read_cnt_reg + LOG_MAX_READS_PER_ITER'(1);
                     state_reg    <= S_WAIT_A;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_batch.sv
// Directed bench for mul_batch: scoreboard of expected groups, immediate-assert checks.
module tb_mul_batch;

   logic        clk;
   logic        rst;
   logic        configure;
   logic [15:0] num_iters;
   logic [15:0] num_reads_per_iter;
   logic [47:0] act_data_in;
   logic        act_valid_in;
   logic        act_avail_out;
   logic [7:0]  weight_data_in;
   logic        weight_valid_in;
   logic        weight_avail_out;
   logic [63:0] data_out;
   logic        valid_out;
   logic        avail_in;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   mul_batch dut (
      .clk(clk), .rst(rst), .configure(configure),
      .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
      .act_data_in(act_data_in), .act_valid_in(act_valid_in), .act_avail_out(act_avail_out),
      .weight_data_in(weight_data_in), .weight_valid_in(weight_valid_in),
      .weight_avail_out(weight_avail_out),
      .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
      int ia;
      int ib;
`ifdef MUL_BATCH_SIGNED_EN
      ia = $signed(a);
      ib = $signed(b);
`else
      ia = int'(a);
      ib = int'(b);
`endif
      return 16'(ia * ib);
   endfunction

   task automatic model(input logic [31:0] vals, input logic [15:0] mat, input logic [7:0] w,
                        output logic [63:0] exp, output int nrows);
      logic [3:0] row;
      exp   = '0;
      nrows = 0;
      for (int r = 0; r < 4; r++) begin
         row = mat[r*4 +: 4];
         if (row != 4'd0) nrows++;
         for (int c = 0; c < 4; c++) begin
            if (row[c]) exp[c*16 +: 16] = mul8(vals[r*8 +: 8], w);
         end
      end
      if (nrows == 0) nrows = 1;
   endtask

   task automatic send_weight(input logic [7:0] w);
      int k = 0;
      while (!weight_avail_out && k < 100) begin tick(); k++; end
      check("weight_avail_before_load", 64'(weight_avail_out), 64'd1);
      weight_data_in  = w;
      weight_valid_in = 1'b1;
      tick();
      weight_valid_in = 1'b0;
      check("act_avail_after_weight", 64'(act_avail_out), 64'd1);
      check("weight_avail_after_weight", 64'(weight_avail_out), 64'd0);
   endtask

   task automatic send_group(input string tag, input logic [31:0] vals, input logic [15:0] mat,
                             input logic [7:0] w, input int stall);
      logic [63:0] exp;
      logic [63:0] got;
      int nrows;
      int k;
      model(vals, mat, w, exp, nrows);
      k = 0;
      while (!act_avail_out && k < 100) begin tick(); k++; end
      act_data_in  = {mat, vals};
      act_valid_in = 1'b1;
      avail_in     = (stall == 0);
      tick();
      act_valid_in = 1'b0;
      exp_q.push_back(exp);
      k = 0;
      while (!valid_out && k < 100) begin tick(); k++; end
      check({tag, "_comp_cycles"}, 64'(k), 64'(nrows));
      for (int s = 0; s < stall; s++) begin
         check({tag, "_stall_valid"}, 64'(valid_out), 64'd1);
         check({tag, "_stall_data"}, data_out, exp_q[0]);
         check({tag, "_stall_act_avail"}, 64'(act_avail_out), 64'd0);
         tick();
      end
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         got = exp_q.pop_front();
         check({tag, "_data_out"}, data_out, got);
      end
      check({tag, "_valid"}, 64'(valid_out), 64'd1);
      avail_in = 1'b1;
      tick();
      check({tag, "_valid_drop"}, 64'(valid_out), 64'd0);
      $display("group %s vals=%h mat=%h w=%h exp=%h cycles=%0d", tag, vals, mat, w, exp, k);
   endtask

   initial begin
      rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
      act_data_in = '0; act_valid_in = 1'b0; weight_data_in = '0; weight_valid_in = 1'b0;
      avail_in = 1'b1;

      // Reset state
      tick();
      check("rst_weight_avail", 64'(weight_avail_out), 64'd0);
      check("rst_act_avail", 64'(act_avail_out), 64'd0);
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_data", data_out, 64'd0);
      rst = 1'b1;
      tick();
      check("idle_weight_avail", 64'(weight_avail_out), 64'd0);

      configure = 1'b1; num_iters = 16'd2; num_reads_per_iter = 16'd4;
      tick();
      configure = 1'b0;
      check("cfg_weight_avail", 64'(weight_avail_out), 64'd1);
      check("cfg_act_avail", 64'(act_avail_out), 64'd0);
      check("cfg_valid", 64'(valid_out), 64'd0);

      // Iteration 0: one row broadcasting to all lanes
      send_weight(8'd1);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] v;
         v = 8'(i + 1);
         send_group("bcast", {v, v, v, v}, 16'h000F, 8'd1, 0);
      end
      check("reload_weight_avail", 64'(weight_avail_out), 64'd1);
      check("reload_act_avail", 64'(act_avail_out), 64'd0);

      // Iteration 1: mixed sharing, stall, empty matrix, overlapping rows
      send_weight(8'd2);
      send_group("share", {8'd3, 8'd1, 8'd2, 8'd1}, 16'h8025, 8'd2, 0);
      send_group("stall", {8'd8, 8'd7, 8'd6, 8'd5}, 16'h8421, 8'd2, 5);
      check("after_stall_act_avail", 64'(act_avail_out), 64'd1);
      send_group("zero", {8'd9, 8'd9, 8'd9, 8'd9}, 16'h0000, 8'd2, 0);
      send_group("overlap", {8'd40, 8'd30, 8'd20, 8'd10}, 16'h2003, 8'd2, 0);
      check("done_weight_avail", 64'(weight_avail_out), 64'd0);
      check("done_act_avail", 64'(act_avail_out), 64'd0);
      tick(); tick();
      check("done_hold_valid", 64'(valid_out), 64'd0);
      check("done_hold_weight_avail", 64'(weight_avail_out), 64'd0);

      // configure mid-COMP drops the group
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd1;
      tick();
      configure = 1'b0;
      send_weight(8'd3);
      act_data_in = {16'h8421, 8'd4, 8'd3, 8'd2, 8'd1};
      act_valid_in = 1'b1;
      tick();
      act_valid_in = 1'b0;
      tick();
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd0;
      tick();
      configure = 1'b0;
      check("midcomp_cfg_valid", 64'(valid_out), 64'd0);
      check("midcomp_cfg_weight_avail", 64'(weight_avail_out), 64'd1);
      tick(); tick(); tick();
      check("midcomp_cfg_no_late_valid", 64'(valid_out), 64'd0);

      // num_reads_per_iter=0 behaves as one read; wide operands
      send_weight(8'hFF);
      send_group("wide", {8'h80, 8'h00, 8'h02, 8'hFF}, 16'h8421, 8'hFF, 0);
      check("reads0_done_weight_avail", 64'(weight_avail_out), 64'd0);
      check("reads0_done_act_avail", 64'(act_avail_out), 64'd0);

      // reset mid-OUT
      configure = 1'b1; num_iters = 16'd1; num_reads_per_iter = 16'd1;
      tick();
      configure = 1'b0;
      send_weight(8'd5);
      act_data_in = {16'h000F, 8'd1, 8'd1, 8'd1, 8'd7};
      act_valid_in = 1'b1;
      avail_in = 1'b0;
      tick();
      act_valid_in = 1'b0;
      begin
         int k = 0;
         while (!valid_out && k < 100) begin tick(); k++; end
      end
      check("preout_valid", 64'(valid_out), 64'd1);
      check("preout_data", data_out, {16'd35, 16'd35, 16'd35, 16'd35});
      rst = 1'b0;
      tick();
      rst = 1'b1;
      avail_in = 1'b1;
      check("midout_rst_valid", 64'(valid_out), 64'd0);
      check("midout_rst_data", data_out, 64'd0);
      check("midout_rst_weight_avail", 64'(weight_avail_out), 64'd0);
      tick();
      check("midout_rst_idle", 64'(weight_avail_out), 64'd0);

      // num_iters=0 goes straight to DONE
      configure = 1'b1; num_iters = 16'd0; num_reads_per_iter = 16'd3;
      tick();
      configure = 1'b0;
      check("iters0_weight_avail", 64'(weight_avail_out), 64'd0);
      check("iters0_act_avail", 64'(act_avail_out), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_batch.md
Name: mul_batch

Overview:
- Weight-times-activation batch multiplier with repetition-aware multiplier sharing.
- Per iteration it takes one weight, then a configured number of activation groups (GROUP_SIZE lanes each). Each group carries a repetition matrix, so each unique value is multiplied once and the product is broadcast to every lane holding a duplicate.
- Sits between the activation dispatcher and the accumulation stage.

Parameters:
- DATA_WIDTH, 8, width of activation lanes and of the weight.
- GROUP_SIZE, 4, lanes per activation group.
- LOG_MAX_ITERS, 16, width of num_iters.
- LOG_MAX_READS_PER_ITER, 16, width of num_reads_per_iter.
- REP_INFO, GROUP_SIZE*GROUP_SIZE, width of the repetition matrix.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- configure  in  1  when high, latch num_iters and num_reads_per_iter and restart.
- num_iters  in  LOG_MAX_ITERS  number of weights (iterations) to process.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  activation groups per weight.
- act_data_in  in  GROUP_SIZE*DATA_WIDTH+REP_INFO  bits [k*DW+:DW] = lane k value; upper REP_INFO bits = matrix, with bit r*GROUP_SIZE+c meaning "lane c takes lane r's product".
- act_valid_in  in  1  activation group valid.
- act_avail_out  out  1  block can accept an activation group.
- weight_data_in  in  DATA_WIDTH  weight.
- weight_valid_in  in  1  weight valid.
- weight_avail_out  out  1  block can accept a weight.
- data_out  out  GROUP_SIZE*2*DATA_WIDTH  lane k product at [k*2DW+:2DW].
- valid_out  out  1  data_out valid.
- avail_in  in  1  downstream can accept data_out.

Behaviour:
- Reset (rst=0 at an edge):
  - state IDLE; counters, weight, activation and output registers cleared.
  - act_avail_out=0, weight_avail_out=0, valid_out=0, data_out=0.
- configure=1 in any state:
  - latches both counts, clears iteration and read counters, drops any in-flight group.
  - next state WAIT_W, or DONE if num_iters=0.
- States and transitions:
  - IDLE: wait for configure.
  - WAIT_W: weight_avail_out=1; when weight_valid_in=1, register the weight and go to WAIT_A.
  - WAIT_A: act_avail_out=1; when act_valid_in=1, register lane values and matrix, clear the lane product registers, go to COMP.
  - COMP: each cycle, take the lowest-index row r whose matrix row is nonzero and not yet done. Compute value[r]*weight as a 2*DATA_WIDTH product. Write it to every lane c with bit r*G+c = 1, then mark r done.
    - The last representative row moves to OUT; an all-zero matrix moves to OUT after 1 cycle.
    - COMP lasts max(1, number of nonzero rows) cycles; there is exactly one multiplier instance.
  - OUT: valid_out=1 and data_out held stable until avail_in=1. On that handshake, increment the read counter.
    - Reads still pending for this weight: go to WAIT_A.
    - Last read of the iteration: clear the read counter and increment the iteration counter.
    - More iterations remain: go to WAIT_W (the weight is reloaded).
    - No iterations remain: go to DONE.
  - DONE: all avail/valid outputs low until the next configure.
- Conflict resolution: a lane referenced by no row outputs 0. A lane referenced by several rows takes the highest-index row's product (last write wins).
- Arithmetic: unsigned by default; full product width, no truncation or saturation.
- Latency: activation accept at cycle t, valid_out rises at t+1+max(1,nrows).
- act_avail_out and weight_avail_out are never both high; neither is high in COMP or OUT.
- A num_reads_per_iter value of 0 is treated as 1.

Optional Feature:
- Macro MUL_BATCH_SIGNED_EN.
- Defined: lane values and weight are two's complement, and the product is a sign-correct 2*DATA_WIDTH result.
- Undefined: unsigned multiply.
- Handshake and timing are identical in both builds.

Test Plan:
1. Reset held 1 cycle, then configure with num_iters=2, num_reads=4 -> weight_avail_out=1, act_avail_out=0, valid_out=0.
2. Weight 1, group values {1,1,1,1} with matrix bits 0..3 set (row 0 covers all lanes) -> 1 COMP cycle, data_out lanes {1,1,1,1}. Repeat for i=0..3 with values i+1 -> outputs i+1 on all lanes, then weight_avail_out=1 again.
3. Weight 2, values {1,2,1,3}, diagonal bits 0,5,15 plus bit 2 (row 0 covers lanes 0 and 2, row 2 empty) -> 3 COMP cycles, data_out {2,4,2,6}.
4. avail_in=0 for 5 cycles in OUT -> valid_out stays 1, data_out stable, act_avail_out=0; accepted on the cycle avail_in returns to 1.
5. Matrix all zero -> 1 COMP cycle, all lanes 0. Lane 1 referenced by rows 0 and 3 -> lane 1 = value[3]*weight.
6. configure mid-COMP, and separately rst=0 mid-OUT -> in-flight group dropped, valid_out=0 next cycle; state WAIT_W after configure, IDLE after reset.
